// File: rtl/sigcomp_pkg.sv
// Shared types and constants for the y-bus signature compactor.
// Holds the FSM state encoding and MISR defaults.
package sigcomp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEF_SEED = 32'hFFFFFFFF;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/misr32_step.sv
// One MISR update: shift left, apply feedback, fold in a chunk.
// Purely combinational so the checker-side model can reuse it.
module misr32_step (
  input  logic [31:0] i_misr,
  input  logic [31:0] i_chunk,
  input  logic [31:0] i_poly,
  output logic [31:0] o_misr
);

  logic [31:0] w_fb;

  assign w_fb   = i_misr[31] ? i_poly : 32'h0;
  assign o_misr = {i_misr[30:0], 1'b0} ^ w_fb ^ i_chunk;

endmodule

// File: rtl/y_signature_compactor.sv
// Folds wide y samples into a 32-bit MISR, one chunk per cycle.
// Presents the final signature after NUM_SAMPLES samples.
module y_signature_compactor
  import sigcomp_pkg::*;
#(
  parameter int          Y_WIDTH     = 567,
  parameter int          CHUNK       = 32,
  parameter int          NUM_SAMPLES = 22,
  parameter logic [31:0] POLY        = DEF_POLY,
  parameter logic [31:0] SEED        = DEF_SEED
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [Y_WIDTH-1:0] y_in,
  input  logic               y_valid,
  output logic               y_ready,
  output logic [31:0]        sig_out,
  output logic               sig_valid,
  output logic [7:0]         sample_cnt
);

  localparam int NCHUNK = ceil_div(Y_WIDTH, CHUNK);
  localparam int PADW   = NCHUNK * CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t              r_state;
  state_t              w_state_n;
  logic [Y_WIDTH-1:0]  r_cap;
  logic [IDXW-1:0]     r_idx;
  logic [31:0]         r_misr;
  logic [7:0]          r_cnt;
  logic [PADW-1:0]     w_pad;
  logic [31:0]         w_chunk;
  logic [31:0]         w_misr_n;
  logic                w_last;
  logic                w_more;
  logic                w_ready;
  logic                w_acc;

  // Zero-extend the captured sample so every chunk is full width.
  always_comb begin
    w_pad = '0;
    w_pad[Y_WIDTH-1:0] = r_cap;
  end

  // Select the chunk addressed by the fold index; chunk 0 is the LSBs.
  always_comb begin
    w_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (r_idx == IDXW'(i)) w_chunk = w_pad[i*CHUNK +: CHUNK];
    end
  end

  misr32_step u_step (
    .i_misr  (r_misr),
    .i_chunk (w_chunk),
    .i_poly  (POLY),
    .o_misr  (w_misr_n)
  );

  assign w_last = (r_idx == IDXW'(NCHUNK - 1));
  assign w_more = (9'(r_cnt) + 9'd1) < 9'(NUM_SAMPLES);

  // Ready in IDLE, or on the final fold cycle if more samples remain.
  always_comb begin
    w_ready = 1'b0;
    unique case (r_state)
      IDLE:    w_ready = 1'b1;
      FOLD:    w_ready = w_last && w_more;
      DONE:    w_ready = 1'b0;
      default: w_ready = 1'b0;
    endcase
  end

  assign w_acc = y_valid && w_ready;

  // Next-state logic; a same-cycle accept keeps the fold going.
  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE: if (w_acc) w_state_n = FOLD;
      FOLD: begin
        if (w_last) begin
          if (w_acc)        w_state_n = FOLD;
          else if (!w_more) w_state_n = DONE;
          else              w_state_n = IDLE;
        end
      end
      DONE:    w_state_n = DONE;
      default: w_state_n = IDLE;
    endcase
  end

  // State, capture, index, MISR and count; clear acts exactly like rst.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_state <= IDLE;
      r_cap   <= '0;
      r_idx   <= '0;
      r_misr  <= SEED;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_n;
      if (w_acc) r_cap <= y_in;
      if (r_state == FOLD) begin
        r_misr <= w_misr_n;
        if (w_last) begin
          r_idx <= '0;
          if (9'(r_cnt) < 9'(NUM_SAMPLES)) r_cnt <= r_cnt + 8'd1;
        end else begin
          r_idx <= r_idx + IDXW'(1);
        end
      end else if (w_acc) begin
        r_idx <= '0;
      end
    end
  end

  assign y_ready    = w_ready;
  assign sig_out    = r_misr;
  assign sig_valid  = (r_state == DONE);
  assign sample_cnt = r_cnt;

endmodule
